// File: rtl/grid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grid_arbiter
// Brief    : Round-robin arbiter giving N_REQ requesters access to one memory
//            port, with a test-and-set read lock and a lock watchdog.
// Revision : 1.0
// ============================================================================
module grid_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    lock_err,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_din,
    input  logic [DATA_W-1:0]       mem_dout
);
    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_cnt_w = $clog2(LOCK_MAX + 1);
    localparam logic [c_ptr_w:0]   c_n_req    = (c_ptr_w+1)'(N_REQ);
    localparam logic [c_ptr_w-1:0] c_last     = c_ptr_w'(N_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LOCK_MAX - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_resp  = 2'd3;

    logic [1:0]         r_state, w_next_state;
    logic [c_ptr_w-1:0] r_ptr, r_win, r_owner, w_win, w_next_ptr;
    logic               r_we, r_locked;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N_REQ-1:0]   w_elig;
    logic [c_ptr_w:0]   w_idx;
    logic               w_found, w_grant, w_timeout, w_sel_we, w_sel_lock;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_din;

    assign w_timeout  = r_locked && (r_cnt == c_cnt_last);
    assign w_grant    = (r_state == c_idle) && w_found;
    assign w_next_ptr = (w_win == c_last) ? '0 : w_win + 1'b1;

    // A timeout on the same edge as a decision reopens arbitration to everyone.
    always_comb begin
        w_elig = req;
        if (r_locked && !w_timeout) begin
            w_elig = req & (N_REQ'(1) << r_owner);
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (c_ptr_w+1)'(i);
            if (w_idx >= c_n_req) begin
                w_idx = w_idx - c_n_req;
            end
            if (!w_found && w_elig[w_idx[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_ptr_w-1:0];
            end
        end
    end

    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_lock = 1'b0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (c_ptr_w'(j) == w_win) begin
                w_sel_we   = we[j];
                w_sel_lock = lock[j];
                w_sel_addr = addr[j*ADDR_W +: ADDR_W];
                w_sel_din  = wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_grant) w_next_state = c_issue;
            c_issue: w_next_state = r_we ? c_idle : c_wait;
            c_wait:  w_next_state = c_resp;
            c_resp:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        gnt       = '0;
        rvalid    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (r_state)
            c_issue: begin
                gnt       = N_REQ'(1) << r_win;
                mem_read  = !r_we;
                mem_write = r_we;
            end
            c_resp:  rvalid = N_REQ'(1) << r_win;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr    <= '0;
            r_win    <= '0;
            r_we     <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_ptr    <= w_next_ptr;
                r_win    <= w_win;
                r_we     <= w_sel_we;
                mem_addr <= w_sel_addr;
                mem_din  <= w_sel_din;
            end
            if (r_state == c_wait) begin
                rdata <= mem_dout;
            end
        end
    end

    // A write carrying lock=1 neither takes nor drops the lock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_locked <= 1'b0;
            r_owner  <= '0;
            r_cnt    <= '0;
            lock_err <= 1'b0;
        end else begin
            lock_err <= w_timeout;
            if (w_grant && w_sel_lock && !w_sel_we) begin
                r_locked <= 1'b1;
                r_owner  <= w_win;
                r_cnt    <= '0;
            end else if (w_timeout) begin
                r_locked <= 1'b0;
                r_cnt    <= '0;
            end else if (w_grant && r_locked && !w_sel_lock) begin
                r_locked <= 1'b0;
                r_cnt    <= '0;
            end else if (r_locked) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_grid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_arbiter
// Brief    : Directed and random checks of grid_arbiter against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_grid_arbiter;
    localparam int N = 4, AW = 32, DW = 32, LMAX = 64;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0] gnt, rvalid;
    logic [DW-1:0] rdata, mem_din, mem_dout;
    logic lock_err, mem_read, mem_write;
    logic [AW-1:0] mem_addr;

    grid_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .lock_err(lock_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout));

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? '1 : DW'(a * 7 + 3);
    endfunction

    // Memory device: read data appears the cycle after the strobe is sampled.
    logic [DW-1:0] mem [64];
    bit            vld [64];
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_din;
            vld[mem_addr[5:0]] <= 1'b1;
        end
        if (mem_read) mem_dout <= vld[mem_addr[5:0]] ? mem[mem_addr[5:0]] : init_val(int'(mem_addr[5:0]));
    end

    int total = 0, bad = 0;
    int e = 0;
    int ptr, free_edge, lock_edge, owner, rv_edge, rv_who;
    bit locked, rv_pending;
    logic [DW-1:0] rv_data;
    logic [DW-1:0] ref_mem [64];
    logic [N-1:0] exp_gnt, exp_rvalid;
    bit exp_rd, exp_wr, exp_err;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din, exp_rdata;
    int gnt_q[$];
    int gnt_edge [N];
    logic [DW-1:0] last_rd [N];
    int wr_count, err_edge;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        ptr = 0; free_edge = 0; locked = 0; rv_pending = 0; owner = 0; lock_edge = 0;
    endtask

    // Applied once per rising edge with the inputs the DUT saw on that edge.
    task automatic model_edge();
        int w;
        logic [N-1:0] elig;
        logic [AW-1:0] a;
        exp_gnt = '0; exp_rvalid = '0; exp_rd = 0; exp_wr = 0; exp_err = 0;
        if (!reset) return;
        if (locked && e == lock_edge + LMAX) begin
            locked = 0;
            exp_err = 1;
        end
        if (rv_pending && e == rv_edge) begin
            exp_rvalid = N'(1) << rv_who;
            exp_rdata = rv_data;
            rv_pending = 0;
        end
        if (e >= free_edge) begin
            elig = locked ? (req & (N'(1) << owner)) : req;
            w = -1;
            for (int i = 0; i < N; i++) if (w < 0 && elig[(ptr + i) % N]) w = (ptr + i) % N;
            if (w >= 0) begin
                a = addr[w*AW +: AW];
                exp_gnt = N'(1) << w;
                exp_addr = a;
                if (we[w]) begin
                    exp_wr = 1;
                    exp_din = wdata[w*DW +: DW];
                    ref_mem[a[5:0]] = exp_din;
                    free_edge = e + 2;
                end else begin
                    exp_rd = 1;
                    rv_pending = 1; rv_edge = e + 2; rv_who = w;
                    rv_data = ref_mem[a[5:0]];
                    free_edge = e + 4;
                end
                ptr = (w + 1) % N;
                if (!we[w] && lock[w]) begin
                    locked = 1; owner = w; lock_edge = e;
                end else if (locked && !lock[w]) begin
                    locked = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("rvalid", 64'(rvalid), 64'(exp_rvalid));
        chk("mem_read", 64'(mem_read), 64'(exp_rd));
        chk("mem_write", 64'(mem_write), 64'(exp_wr));
        chk("lock_err", 64'(lock_err), 64'(exp_err));
        if (exp_rd || exp_wr) chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        if (exp_wr) chk("mem_din", 64'(mem_din), 64'(exp_din));
        if (exp_rvalid != 0) chk("rdata", 64'(rdata), 64'(exp_rdata));
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin gnt_q.push_back(k); gnt_edge[k] = e; end
            if (rvalid[k]) last_rd[k] = rdata;
        end
        if (mem_write) wr_count++;
        if (lock_err) err_edge = e;
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
        model_edge();
        @(negedge clk);
        check_outputs();
        req = req & ~exp_gnt;
    endtask

    task automatic set_req(input int k, input bit w, input bit l, input int a, input logic [DW-1:0] d);
        req[k] = 1'b1; we[k] = w; lock[k] = l;
        addr[k*AW +: AW] = AW'(a);
        wdata[k*DW +: DW] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 0);
        chk({tag, "_rvalid"}, 64'(rvalid), 0);
        chk({tag, "_rdata"}, 64'(rdata), 0);
        chk({tag, "_strobes"}, 64'({mem_read, mem_write, lock_err}), 0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
        chk({tag, "_mem_din"}, 64'(mem_din), 0);
    endtask

    initial begin
        int exp_order [5];
        bit seen;
        bit wb, lk;
        reset = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        for (int a = 0; a < 64; a++) ref_mem[a] = init_val(a);
        model_reset();
        err_edge = -1; wr_count = 0;
        for (int k = 0; k < N; k++) begin gnt_edge[k] = -1; last_rd[k] = '0; end

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Four reads in round-robin order, requester 0 asks again
        for (int k = 0; k < N; k++) set_req(k, 0, 0, 10 + k, '0);
        gnt_q.delete();
        tick();
        set_req(0, 0, 0, 10, '0);
        repeat (19) tick();
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_count", 64'(gnt_q.size()), 5);
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < gnt_q.size()) ? 64'(gnt_q[i]) : '1, 64'(exp_order[i]));
        chk("rr_rdata", 64'(last_rd[0]), 64'(init_val(10)));

        // Write then read back
        wr_count = 0;
        set_req(1, 1, 0, 40, 7);
        repeat (4) tick();
        set_req(1, 0, 0, 40, '0);
        repeat (6) tick();
        chk("wr_once", 64'(wr_count), 1);
        chk("rd_after_wr", 64'(last_rd[1]), 7);

        // Lock held by requester 2 blocks requester 0 until released by a write
        gnt_q.delete();
        set_req(2, 0, 1, 5, '0);
        tick();
        set_req(0, 0, 0, 3, '0);
        repeat (10) tick();
        chk("lock_blocks", 64'(gnt_q.size()), 1);
        chk("lock_rdata", 64'(last_rd[2]), 64'(32'hFFFF_FFFF));
        set_req(2, 1, 0, 5, 32'h55);
        repeat (8) tick();
        chk("unlock_count", 64'(gnt_q.size()), 3);
        if (gnt_q.size() == 3) begin
            chk("unlock_wr", 64'(gnt_q[1]), 2);
            chk("unlock_r0", 64'(gnt_q[2]), 0);
        end

        // Lock watchdog
        gnt_q.delete(); err_edge = -1;
        set_req(3, 0, 1, 20, '0);
        tick();
        set_req(0, 0, 0, 21, '0);
        repeat (70) tick();
        chk("timeout_gap", 64'(err_edge - gnt_edge[3]), LMAX);
        chk("timeout_grant", 64'(gnt_edge[0]), 64'(err_edge));
        chk("timeout_order", 64'(gnt_q.size()), 2);

        // Reset in the middle of a read
        seen = 0;
        set_req(1, 0, 0, 12, '0);
        for (int c = 0; c < 8 && !seen; c++) begin
            tick();
            seen = gnt[1];
        end
        chk("abort_setup", 64'(seen), 1);
        tick();
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        gnt_q.delete();
        set_req(1, 0, 0, 1, '0);
        set_req(3, 0, 0, 3, '0);
        repeat (10) tick();
        chk("post_rst_count", 64'(gnt_q.size()), 2);
        if (gnt_q.size() == 2) begin
            chk("post_rst_first", 64'(gnt_q[0]), 1);
            chk("post_rst_second", 64'(gnt_q[1]), 3);
        end

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    wb = 1'($urandom_range(0, 1));
                    lk = !wb && ($urandom_range(0, 3) == 0);
                    set_req(k, wb, lk, int'($urandom_range(0, 63)), $urandom);
                end else if (req[k] && $urandom_range(0, 15) == 0) begin
                    req[k] = 1'b0;
                end
            end
            tick();
        end
        req = '0;
        repeat (70) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
